// File: rtl/uart_frame_parser_if.sv
// Byte-stream in / payload and status out bundle for uart_frame_parser.
// slave: parser side (rx byte in, payload/status out); master: source/sink side.
interface uart_frame_parser_if;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       payload_valid;
  logic [7:0] payload_data;
  logic       payload_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output uart_rx_done,
    output uart_rx_data,
    input  payload_valid,
    input  payload_data,
    input  payload_last,
    input  frame_done,
    input  frame_err,
    input  err_code
  );

  modport slave (
    input  uart_rx_done,
    input  uart_rx_data,
    output payload_valid,
    output payload_data,
    output payload_last,
    output frame_done,
    output frame_err,
    output err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Extracts HEADER/LEN/payload/XOR-checksum frames from a UART byte stream.
// Ports: clk, rst_n (async low), bus (slave): rx byte in, payload + status out.
module uart_frame_parser #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          UART_BPS      = 115200,
  parameter logic [7:0]  HEADER        = 8'h55,
  parameter int          MAX_LEN       = 16,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int TIMEOUT_CYC =
    (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
  // Error is registered on the edge where the counter
  // would step onto TIMEOUT_CYC-1.
  localparam logic [23:0] TMO_HIT = 24'(TIMEOUT_CYC - 2);
  localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHKSUM
  } state_t;

  state_t      r_state;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [7:0]  r_chk;
  logic [23:0] r_tmo;
  logic        r_pv;
  logic [7:0]  r_pd;
  logic        r_pl;
  logic        r_fd;
  logic        r_fe;
  logic [1:0]  r_ec;

  logic       w_rx;
  logic [7:0] w_data;
  logic       w_tmo;

  assign w_rx   = bus.uart_rx_done;
  assign w_data = bus.uart_rx_data;
  assign w_tmo  = (r_state != IDLE) && (r_tmo == TMO_HIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_tmo   <= '0;
      r_pv    <= 1'b0;
      r_pd    <= '0;
      r_pl    <= 1'b0;
      r_fd    <= 1'b0;
      r_fe    <= 1'b0;
      r_ec    <= '0;
    end else begin
      r_pv <= 1'b0;
      r_pl <= 1'b0;
      r_fd <= 1'b0;
      r_fe <= 1'b0;

      if (w_rx || r_state == IDLE)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 24'd1;

      // A byte arriving on the expiry cycle wins.
      if (!w_rx && w_tmo) begin
        r_fe    <= 1'b1;
        r_ec    <= 2'd3;
        r_tmo   <= '0;
        r_state <= IDLE;
      end else if (w_rx) begin
        unique case (r_state)
          IDLE: begin
            if (w_data == HEADER)
              r_state <= LEN;
          end
          LEN: begin
            if (w_data == 8'd0 || w_data > MAX_B) begin
              r_fe    <= 1'b1;
              r_ec    <= 2'd1;
              r_state <= IDLE;
            end else begin
              r_len   <= w_data;
              r_chk   <= w_data;
              r_cnt   <= '0;
              r_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_pv  <= 1'b1;
            r_pd  <= w_data;
            r_chk <= r_chk ^ w_data;
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_len - 8'd1) begin
              r_pl    <= 1'b1;
              r_state <= CHKSUM;
            end
          end
          CHKSUM: begin
            if (w_data == r_chk) begin
              r_fd <= 1'b1;
            end else begin
              r_fe <= 1'b1;
              r_ec <= 2'd2;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.payload_valid = r_pv;
  assign bus.payload_data  = r_pd;
  assign bus.payload_last  = r_pl;
  assign bus.frame_done    = r_fd;
  assign bus.frame_err     = r_fe;
  assign bus.err_code      = r_ec;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected pulses queued at drive
// time with their due cycle, popped and compared by a negedge monitor.
module tb_uart_frame_parser;

  localparam int T = (50000000 / 115200) * 10 * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_parser_if bus();

  uart_frame_parser #(
    .CLK_FREQ(50000000),
    .UART_BPS(115200),
    .HEADER(8'h55),
    .MAX_LEN(16),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    logic [1:0] code;
    longint     due;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  logic [1:0] last_code = 2'd0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && (bus.payload_valid || bus.frame_done
                  || bus.frame_err)) begin : mon
      int   k;
      exp_t e;
      k = bus.payload_valid ? 0 : (bus.frame_done ? 1 : 2);
      checks++;
      if ($countones({bus.payload_valid, bus.frame_done,
                      bus.frame_err}) != 1) begin
        failures++;
        $display("FAIL multi_pulse cyc=%0d got=%b%b%b want one",
                 cyc, bus.payload_valid, bus.frame_done,
                 bus.frame_err);
      end
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output kind=%0d cyc=%0d", k, cyc);
      end else begin
        e = q.pop_front();
        if (k != e.kind || cyc != e.due) begin
          failures++;
          $display("FAIL event kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                   k, cyc, e.kind, e.due);
        end else if (k == 0) begin
          checks++;
          if (bus.payload_data !== e.data
              || bus.payload_last !== e.last) begin
            failures++;
            $display("FAIL payload data=%h last=%b want %h %b",
                     bus.payload_data, bus.payload_last,
                     e.data, e.last);
          end
        end else if (k == 2) begin
          checks++;
          last_code = e.code;
          if (bus.err_code !== e.code) begin
            failures++;
            $display("FAIL err_code got=%0d want=%0d",
                     bus.err_code, e.code);
          end
        end else begin
          checks++;
          if (bus.err_code !== last_code) begin
            failures++;
            $display("FAIL err_code_hold got=%0d want=%0d",
                     bus.err_code, last_code);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d,
                      input logic l, input logic [1:0] c,
                      input longint due);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.last = l;
    e.code = c;
    e.due  = due;
    q.push_back(e);
  endtask

  // Drives n bytes back to back, first byte is the top of v[8n-1:0].
  task automatic stream(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.uart_rx_done = 1'b1;
      bus.uart_rx_data = v[8*(n-1-i) +: 8];
      @(posedge clk);
      #1;
    end
    bus.uart_rx_done = 1'b0;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < n && q.size() != 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.payload_valid, bus.payload_data, bus.payload_last,
         bus.frame_done, bus.frame_err, bus.err_code} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want 0",
               {bus.payload_valid, bus.payload_data, bus.payload_last,
                bus.frame_done, bus.frame_err, bus.err_code});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h11, 1'b0, 2'd0, b + 3);
    push(0, 8'h22, 1'b0, 2'd0, b + 4);
    push(0, 8'h33, 1'b1, 2'd0, b + 5);
    push(1, 8'h00, 1'b0, 2'd0, b + 6);
    stream(128'h55_03_11_22_33_03, 6);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL good_missing left=%0d want 0", q.size());
    end
  endtask

  task automatic test_bad_chk();
    longint b;
    sync();
    b = cyc;
    push(0, 8'hAA, 1'b0, 2'd0, b + 3);
    push(0, 8'hBB, 1'b1, 2'd0, b + 4);
    push(2, 8'h00, 1'b0, 2'd2, b + 5);
    stream(128'h55_02_AA_BB_10, 5);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL bad_chk_missing left=%0d want 0", q.size());
    end
  endtask

  task automatic test_bad_len(input logic [7:0] len);
    longint b;
    sync();
    b = cyc;
    push(2, 8'h00, 1'b0, 2'd1, b + 2);
    push(0, 8'h7E, 1'b1, 2'd0, b + 5);
    push(1, 8'h00, 1'b0, 2'd0, b + 6);
    stream({80'd0, 8'h55, len, 32'h55_01_7E_7F}, 6);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL bad_len_%h_missing left=%0d want 0",
               len, q.size());
    end
  endtask

  task automatic test_timeout();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h41, 1'b0, 2'd0, b + 3);
    push(2, 8'h00, 1'b0, 2'd3, b + 3 + T - 1);
    stream(128'h55_02_41, 3);
    wait_q(T + 20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL timeout_missing left=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_tmo_race();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h41, 1'b0, 2'd0, b + 3);
    push(0, 8'h42, 1'b1, 2'd0, b + 3 + T - 1);
    push(1, 8'h00, 1'b0, 2'd0, b + 3 + T);
    stream(128'h55_02_41, 3);
    repeat (T - 2) @(posedge clk);
    #1;
    stream(128'h42, 1);
    stream(128'h01, 1);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL tmo_race_missing left=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_junk();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h55, 1'b1, 2'd0, b + 5);
    push(1, 8'h00, 1'b0, 2'd0, b + 6);
    stream(128'h00_FF_55_01_55_54, 6);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL junk_missing left=%0d want 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h7E, 1'b1, 2'd0, b + 3);
    push(1, 8'h00, 1'b0, 2'd0, b + 4);
    push(0, 8'h01, 1'b0, 2'd0, b + 7);
    push(0, 8'h02, 1'b1, 2'd0, b + 8);
    push(1, 8'h00, 1'b0, 2'd0, b + 9);
    stream(128'h55_01_7E_7F_55_02_01_02_01, 9);
    wait_q(20);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing left=%0d want 0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    longint b;
    sync();
    b = cyc;
    push(0, 8'h11, 1'b0, 2'd0, b + 3);
    stream(128'h55_03_11, 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.payload_valid, bus.payload_data, bus.payload_last,
         bus.frame_done, bus.frame_err, bus.err_code} !== 14'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b want 0",
               {bus.payload_valid, bus.payload_data, bus.payload_last,
                bus.frame_done, bus.frame_err, bus.err_code});
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_missing left=%0d want 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
    last_code = 2'd0;
    rst_n = 1'b1;
    test_good();
  endtask

  initial begin
    bus.uart_rx_done = 1'b0;
    bus.uart_rx_data = 8'h00;
    test_reset();
    test_good();
    test_bad_chk();
    test_bad_len(8'h00);
    test_bad_len(8'h11);
    test_timeout();
    test_tmo_race();
    test_junk();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Consumes the byte stream from the UART receiver (`uart_rx_done` / `uart_rx_data`) and extracts length-delimited frames.
- Frame format: HEADER byte, LEN byte, LEN payload bytes, XOR checksum byte.
- Streams payload bytes to the downstream command logic as it receives them.
- Flags frame completion, or one of three errors: bad length, checksum mismatch, inter-byte timeout.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, line baud rate; used only for the timeout.
- HEADER, 8'h55, start-of-frame byte.
- MAX_LEN, 16, largest legal payload length (1..255).
- TIMEOUT_BYTES, 4, inter-byte silence limit in 10-bit character times.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active low.
- uart_rx_done  input  1  single-cycle pulse; a received byte is valid.
- uart_rx_data  input  8  received byte; sampled only when uart_rx_done=1.
- payload_valid  output  1  single-cycle pulse; payload_data holds a payload byte.
- payload_data  output  8  payload byte; holds its value between pulses.
- payload_last  output  1  high together with payload_valid on the final payload byte.
- frame_done  output  1  single-cycle pulse; frame ended with a correct checksum.
- frame_err  output  1  single-cycle pulse; frame aborted.
- err_code  output  2  meaningful when frame_err=1: 1 = bad length, 2 = checksum mismatch, 3 = timeout. Holds its value until the next error.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE; len, cnt, chk and the timeout counter are 0.
- Localparam TIMEOUT_CYC = (CLK_FREQ/UART_BPS)*10*TIMEOUT_BYTES. With defaults this is 434*40 = 17360. The timeout counter is 24 bits wide.
- Latency: every output pulse is registered and appears exactly 1 cycle after the `uart_rx_done` pulse that caused it. Pulses are never longer than 1 cycle.
- State machine:
  - IDLE: on rx_done with data==HEADER go to LEN. Any other byte is silently discarded and the state stays IDLE. No timeout runs in IDLE.
  - LEN: on rx_done:
    - If data==0 or data>MAX_LEN: frame_err with err_code=1, go to IDLE.
    - Otherwise: len<=data, chk<=data, cnt<=0, go to PAYLOAD.
  - PAYLOAD: on rx_done:
    - payload_valid=1, payload_data=data, chk<=chk^data, cnt<=cnt+1.
    - If cnt==len-1: payload_last=1, go to CHKSUM.
  - CHKSUM: on rx_done:
    - If data==chk: frame_done=1.
    - Otherwise: frame_err with err_code=2.
    - Go to IDLE in both cases.
- The checksum covers the LEN byte and all payload bytes. The header is excluded.
- A HEADER value received in LEN, PAYLOAD or CHKSUM is treated as ordinary data. There is no resync mid-frame.
- Timeout:
  - Active in LEN, PAYLOAD and CHKSUM.
  - The counter clears on every rx_done and on entry to IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYC-1: frame_err with err_code=3, go to IDLE.
- Simultaneous rx_done and timeout expiry in the same cycle: the byte wins. It is processed and the counter clears; no timeout is reported.
- Payload bytes are forwarded before the checksum is checked. The consumer must discard buffered bytes on frame_err.
- After frame_done or frame_err the parser is in IDLE on the next cycle and accepts a HEADER immediately. It handles back-to-back frames with zero gap.
- Reset asserted mid-frame: the parser returns to IDLE at once and no pulse is emitted. Partially received bytes are lost.

Test Plan:
- Good frame: bytes 55 03 11 22 33 03 → three payload_valid pulses with data 11, 22, 33; payload_last only on the 33 pulse; frame_done 1 cycle after the 03 checksum byte; frame_err stays 0.
- Bad checksum: 55 02 AA BB 10 (correct value 02^AA^BB = 13) → two payload pulses, then frame_err with err_code=2; no frame_done.
- Bad length:
  - 55 00 → frame_err, err_code=1.
  - 55 11 with MAX_LEN=16 → frame_err, err_code=1.
  - In both cases no payload_valid, and a following 55 01 7E 7F is accepted with frame_done.
- Timeout: 55 02 41, then no rx_done for 17360 cycles → frame_err with err_code=3 exactly TIMEOUT_CYC-1 cycles after the 41 pulse. Also inject rx_done on the expiry cycle and confirm no error is reported.
- Junk and header in payload: 00 FF 55 01 55 54 → the leading 00 FF are ignored; one payload pulse with data 55 and payload_last=1; frame_done (01^55 = 54).
- Reset mid-frame: assert rst_n=0 after 55 03 11 → all outputs 0 at once; after release, a full good frame parses correctly.
